// File: rtl/onn_pkg.sv
// Shared constants and types for the oscillator phase-matrix loader.
package onn_pkg;

    localparam int N_ROWS    = 5;
    localparam int N_COLS    = 3;
    localparam int PHI_W     = 4;
    localparam int NUM_WORDS = N_ROWS * N_COLS;

    // Width helper that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    localparam int NUM_W = clog2_min1(NUM_WORDS);
    localparam int CNT_W = clog2_min1(PHI_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/synapse_phase_loader_if.sv
// Serial load handshake and committed phase-matrix bus of the loader.
interface synapse_phase_loader_if;

    logic                                                start;
    logic                                                abort;
    logic                                                bit_valid;
    logic                                                bit_in;
    logic                                                busy;
    logic [onn_pkg::NUM_W-1:0]                           num;
    logic [0:onn_pkg::NUM_WORDS*onn_pkg::PHI_W-1]        phi_out;
    logic                                                phi_valid;
    logic                                                done;

    modport master (
        output start, abort, bit_valid, bit_in,
        input  busy, num, phi_out, phi_valid, done
    );

    modport slave (
        input  start, abort, bit_valid, bit_in,
        output busy, num, phi_out, phi_valid, done
    );

endinterface

// File: rtl/phase_deserializer.sv
// MSB-first serial-to-parallel converter for one phase word; flags the word
// in the same cycle its final bit is accepted.
module phase_deserializer
    import onn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [PHI_W-1:0] word_o,
    output logic             word_valid_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PHI_W - 1);

    // Only PHI_W-1 bits need storage: the final bit completes the word directly.
    logic [PHI_W-2:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        word_o       = {sreg_q, bit_i};
        word_valid_o = shift_i && !clear_i && (cnt_q == LAST_BIT);
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        if (clear_i) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            sreg_d = word_o[PHI_W-2:0];
            cnt_d  = (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/synapse_phase_loader.sv
// Sequences a serial phase-matrix load into a staging buffer and commits the
// whole matrix to phi_out in a single cycle so consumers never see a partial frame.
module synapse_phase_loader
    import onn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    synapse_phase_loader_if.slave bus
);

    localparam logic [NUM_W-1:0] LAST_NUM = NUM_W'(NUM_WORDS - 1);

    state_e                state_q, state_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  phi_valid_q;
    logic                  commit_en;
    logic                  deser_clear;
    logic                  deser_shift;
    logic [PHI_W-1:0]      word;
    logic                  word_valid;
    logic [0:NUM_WORDS*PHI_W-1] phi_flat;

    phase_deserializer u_deser (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (deser_clear),
        .shift_i      (deser_shift),
        .bit_i        (bus.bit_in),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (word_valid && (num_q == LAST_NUM)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy stays up through the cycle done is shown, so it covers the commit edge.
    always_comb begin
        deser_clear = (state_q != SHIFT) || bus.abort;
        deser_shift = (state_q == SHIFT) && bus.bit_valid && !bus.abort;
        commit_en   = (state_q == COMMIT);
        done_d      = commit_en;
        busy_d      = (state_d != IDLE) || commit_en;
        num_d       = num_q;
        unique case (state_q)
            IDLE:   num_d = '0;
            SHIFT: begin
                if (bus.abort) begin
                    num_d = '0;
                end else if (word_valid && (num_q != LAST_NUM)) begin
                    num_d = num_q + NUM_W'(1);
                end
            end
            COMMIT:  num_d = '0;
            default: num_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            phi_valid_q <= 1'b0;
        end else begin
            num_q       <= num_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            phi_valid_q <= phi_valid_q | commit_en;
        end
    end

    // One staging slot and one committed word per matrix entry, row-major.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
        logic [PHI_W-1:0] stage_q;
        logic [PHI_W-1:0] phi_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
                phi_q   <= '0;
            end else begin
                if (word_valid && (num_q == NUM_W'(gi))) begin
                    stage_q <= word;
                end
                if (commit_en) begin
                    phi_q <= stage_q;
                end
            end
        end

        assign phi_flat[gi*PHI_W +: PHI_W] = phi_q;
    end

    assign bus.busy      = busy_q;
    assign bus.num       = num_q;
    assign bus.done      = done_q;
    assign bus.phi_valid = phi_valid_q;
    assign bus.phi_out   = phi_flat;

endmodule

// File: tb/tb_synapse_phase_loader.sv
// Randomized bench for the phase-matrix loader against a frame-level reference model.
module tb_synapse_phase_loader;
    import onn_pkg::*;

    localparam int NBITS = NUM_WORDS * PHI_W;
    localparam int WMAX  = (1 << PHI_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    synapse_phase_loader_if bus ();

    synapse_phase_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned        frame_w [NUM_WORDS];
    logic [0:NBITS-1]   exp_phi;
    logic               exp_valid;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bit_of(input int b);
        int k;
        int j;
        k = b / PHI_W;
        j = b % PHI_W;
        return 1'((frame_w[k] >> (PHI_W - 1 - j)) & 1);
    endfunction

    function automatic logic [0:NBITS-1] model_phi();
        logic [0:NBITS-1] r;
        r = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            r[k*PHI_W +: PHI_W] = PHI_W'(frame_w[k]);
        end
        return r;
    endfunction

    function automatic int exp_num(input int consumed);
        int n;
        n = consumed / PHI_W;
        return (n > NUM_WORDS - 1) ? NUM_WORDS - 1 : n;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < NUM_WORDS; k++) frame_w[k] = $urandom_range(0, WMAX);
    endtask

    // gap_mode: 0 continuous, 1 alternating valid, 2 random gaps; abort_at < 0 means no abort
    task automatic run_frame(input int gap_mode, input bit spam_start, input int abort_at);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("busy_after_start", 64'(bus.busy), 64'd1);
        check_val("done_after_start", 64'(bus.done), 64'd0);
        check_val("num_after_start", 64'(bus.num), 64'd0);
        for (int b = 0; b < NBITS; b++) begin
            if (b > 0) begin
                int g;
                g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
                for (int i = 0; i < g; i++) begin
                    bus.bit_valid = 1'b0;
                    bus.bit_in    = 1'($urandom_range(0, 1));
                    bus.start     = spam_start;
                    tick();
                    check_val("num_gap", 64'(bus.num), 64'(exp_num(b)));
                end
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = bit_of(b);
            bus.start     = spam_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (b == abort_at) begin
                bus.abort = 1'b1;
                tick();
                bus.abort     = 1'b0;
                bus.bit_valid = 1'b0;
                bus.start     = 1'b0;
                check_val("abort_busy", 64'(bus.busy), 64'd0);
                check_val("abort_done", 64'(bus.done), 64'd0);
                check_val("abort_num", 64'(bus.num), 64'd0);
                check_val("abort_phi", 64'(bus.phi_out), 64'(exp_phi));
                check_val("abort_valid", 64'(bus.phi_valid), 64'(exp_valid));
                tick();
                check_val("abort_busy2", 64'(bus.busy), 64'd0);
                check_val("abort_done2", 64'(bus.done), 64'd0);
                $display("frame aborted at bit %0d", b);
                return;
            end
            tick();
            check_val("num_bit", 64'(bus.num), 64'(exp_num(b + 1)));
            check_val("done_shift", 64'(bus.done), 64'd0);
            check_val("busy_shift", 64'(bus.busy), 64'd1);
        end
        bus.bit_valid = 1'b0;
        bus.start     = 1'b0;
        tick();
        exp_phi   = model_phi();
        exp_valid = 1'b1;
        check_val("commit_done", 64'(bus.done), 64'd1);
        check_val("commit_phi", 64'(bus.phi_out), 64'(exp_phi));
        check_val("commit_valid", 64'(bus.phi_valid), 64'd1);
        check_val("commit_busy", 64'(bus.busy), 64'd1);
        check_val("commit_num", 64'(bus.num), 64'd0);
        $display("frame committed mode=%0d phi=%0h", gap_mode, exp_phi);
    endtask

    task automatic idle_after();
        tick();
        check_val("idle_done", 64'(bus.done), 64'd0);
        check_val("idle_busy", 64'(bus.busy), 64'd0);
        check_val("idle_num", 64'(bus.num), 64'd0);
        check_val("idle_phi", 64'(bus.phi_out), 64'(exp_phi));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        exp_phi       = '0;
        exp_valid     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_num", 64'(bus.num), 64'd0);
        check_val("rst_phi", 64'(bus.phi_out), 64'd0);
        check_val("rst_valid", 64'(bus.phi_valid), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < NUM_WORDS; k++) frame_w[k] = WMAX;
        run_frame(0, 1'b0, -1);
        check_val("all_ones", 64'(bus.phi_out), 64'h0FFF_FFFF_FFFF_FFFF);
        idle_after();

        for (int k = 0; k < NUM_WORDS; k++) frame_w[k] = k;
        run_frame(0, 1'b0, -1);
        idle_after();
        run_frame(1, 1'b0, -1);
        idle_after();

        for (int k = 0; k < NUM_WORDS; k++) frame_w[k] = WMAX;
        run_frame(0, 1'b0, -1);
        idle_after();
        fill_random();
        run_frame(0, 1'b0, 20);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        check_val("start_abort_idle", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        check_val("start_abort_idle2", 64'(bus.busy), 64'd0);

        fill_random();
        run_frame(2, 1'b1, -1);
        idle_after();

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_frame(2, 1'b0, -1);
        end
        idle_after();

        fill_random();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 30; b++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = bit_of(b);
            tick();
        end
        bus.bit_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_phi   = '0;
        exp_valid = 1'b0;
        check_val("async_rst_phi", 64'(bus.phi_out), 64'd0);
        check_val("async_rst_valid", 64'(bus.phi_valid), 64'd0);
        check_val("async_rst_busy", 64'(bus.busy), 64'd0);
        check_val("async_rst_num", 64'(bus.num), 64'd0);
        check_val("async_rst_done", 64'(bus.done), 64'd0);
        $display("async reset applied mid-frame");
        tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_busy", 64'(bus.busy), 64'd0);

        fill_random();
        run_frame(2, 1'b0, -1);
        idle_after();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
